// File: rtl/pkt_demux3.sv
// Store-and-forward demultiplexer: steers a tagged packet stream into three
// per-channel circular buffers and releases only complete packets downstream.
module pkt_demux3 #(
  parameter int DW      = 8,
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_vld,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic [DW-1:0] din,
  input  logic [1:0]    din_chan,
  output logic          data_a_vld,
  output logic          data_a_sop,
  output logic          data_a_eop,
  output logic [DW-1:0] data_a,
  input  logic          data_a_rdy,
  output logic          data_b_vld,
  output logic          data_b_sop,
  output logic          data_b_eop,
  output logic [DW-1:0] data_b,
  input  logic          data_b_rdy,
  output logic          data_c_vld,
  output logic          data_c_sop,
  output logic          data_c_eop,
  output logic [DW-1:0] data_c,
  input  logic          data_c_rdy,
  output logic          drop_pulse,
  output logic [15:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_PKT + 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   MAXP_W  = (AW+1)'(MAX_PKT);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW:0]   ZERO_W  = (AW+1)'(0);
  localparam logic [LW-1:0] MAXL_W  = LW'(MAX_PKT);
  localparam logic [LW-1:0] LONE_W  = LW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [1:0]    chan_q, chan_d;
  logic [AW:0]   start_q, start_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW:0]   wr_ptr_q [3];
  logic [AW:0]   wr_ptr_d [3];
  logic [AW:0]   commit_q [3];
  logic [AW:0]   commit_d [3];
  logic [AW:0]   commit_vis_q [3];
  logic [AW:0]   rd_ptr_q [3];
  logic [AW:0]   rd_ptr_d [3];
  logic [AW:0]   pkt_cnt_q [3];
  logic [AW:0]   pkt_cnt_d [3];
  logic [2:0]    vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic [DW-1:0] data_q [3];
  logic [DW-1:0] data_d [3];
  logic          drop_pulse_q, drop_pulse_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [16:0]   drop_sum;
  logic [1:0]    drop_num;
  logic [2:0]    commit_inc;
  logic [2:0]    rdy_s;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [AW:0]   wr_addr;
  logic [DW+1:0] wr_word;
  logic [AW:0]   free;
  logic [DW+1:0] mem_q [3][DEPTH];

  assign rdy_s = {data_c_rdy, data_b_rdy, data_a_rdy};

  // Input FSM: admission, buffer writes, commit and rollback.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    start_d  = start_q;
    len_d    = len_q;
    for (int c = 0; c < 3; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      commit_d[c] = commit_q[c];
    end
    wr_en      = 1'b0;
    wr_ch      = 2'd0;
    wr_addr    = ZERO_W;
    wr_word    = {din_sop, din_eop, din};
    drop_num   = 2'd0;
    commit_inc = 3'b000;
    free       = ZERO_W;
    if (din_vld && din_sop) begin
      // A sop while receiving abandons the partial packet before the new one is judged.
      if (state_q == RECV) begin
        wr_ptr_d[chan_q] = start_q;
        drop_num         = 2'd1;
      end else begin
        drop_num = 2'd0;
      end
      if (din_chan == 2'd3) begin
        drop_num = drop_num + 2'd1;
        state_d  = din_eop ? IDLE : DROP;
      end else begin
        free = DEPTH_W - (wr_ptr_d[din_chan] - rd_ptr_q[din_chan]);
        if (free < MAXP_W) begin
          drop_num = drop_num + 2'd1;
          state_d  = din_eop ? IDLE : DROP;
        end else begin
          chan_d             = din_chan;
          start_d            = commit_q[din_chan];
          wr_en              = 1'b1;
          wr_ch              = din_chan;
          wr_addr            = wr_ptr_d[din_chan];
          wr_ptr_d[din_chan] = wr_ptr_d[din_chan] + ONE_W;
          len_d              = LONE_W;
          if (din_eop) begin
            commit_d[din_chan]   = wr_ptr_d[din_chan];
            commit_inc[din_chan] = 1'b1;
            state_d              = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end
    end else if (din_vld) begin
      case (state_q)
        RECV: begin
          if (len_q == MAXL_W) begin
            wr_ptr_d[chan_q] = start_q;
            drop_num         = 2'd1;
            state_d          = din_eop ? IDLE : DROP;
          end else begin
            wr_en            = 1'b1;
            wr_ch            = chan_q;
            wr_addr          = wr_ptr_q[chan_q];
            wr_ptr_d[chan_q] = wr_ptr_q[chan_q] + ONE_W;
            len_d            = len_q + LONE_W;
            if (din_eop) begin
              commit_d[chan_q]   = wr_ptr_d[chan_q];
              commit_inc[chan_q] = 1'b1;
              state_d            = IDLE;
            end else begin
              state_d = RECV;
            end
          end
        end
        DROP:    state_d = din_eop ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    drop_sum     = {1'b0, drop_cnt_q} + {15'd0, drop_num};
    drop_cnt_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    drop_pulse_d = (drop_num != 2'd0);
  end

  // Per-channel output register; commit becomes visible one cycle late via commit_vis_q.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      rd_ptr_d[c] = rd_ptr_q[c];
      vld_d[c]    = vld_q[c];
      sop_d[c]    = sop_q[c];
      eop_d[c]    = eop_q[c];
      data_d[c]   = data_q[c];
      if ((rd_ptr_q[c] != commit_vis_q[c]) && (pkt_cnt_q[c] != ZERO_W) &&
          (!vld_q[c] || rdy_s[c])) begin
        {sop_d[c], eop_d[c], data_d[c]} = mem_q[c][rd_ptr_q[c][AW-1:0]];
        vld_d[c]    = 1'b1;
        rd_ptr_d[c] = rd_ptr_q[c] + ONE_W;
      end else if (rdy_s[c]) begin
        vld_d[c] = 1'b0;
      end else begin
        vld_d[c] = vld_q[c];
      end
      pkt_cnt_d[c] = pkt_cnt_q[c] + (commit_inc[c] ? ONE_W : ZERO_W)
                     - ((vld_q[c] && rdy_s[c] && eop_q[c]) ? ONE_W : ZERO_W);
    end
  end

  // Buffer RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ch][wr_addr[AW-1:0]] <= wr_word;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chan_q       <= 2'd0;
      start_q      <= ZERO_W;
      len_q        <= '0;
      vld_q        <= 3'b000;
      sop_q        <= 3'b000;
      eop_q        <= 3'b000;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 16'h0000;
      for (int c = 0; c < 3; c++) begin
        wr_ptr_q[c]     <= ZERO_W;
        commit_q[c]     <= ZERO_W;
        commit_vis_q[c] <= ZERO_W;
        rd_ptr_q[c]     <= ZERO_W;
        pkt_cnt_q[c]    <= ZERO_W;
        data_q[c]       <= '0;
      end
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      start_q      <= start_d;
      len_q        <= len_d;
      vld_q        <= vld_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
      for (int c = 0; c < 3; c++) begin
        wr_ptr_q[c]     <= wr_ptr_d[c];
        commit_q[c]     <= commit_d[c];
        commit_vis_q[c] <= commit_q[c];
        rd_ptr_q[c]     <= rd_ptr_d[c];
        pkt_cnt_q[c]    <= pkt_cnt_d[c];
        data_q[c]       <= data_d[c];
      end
    end
  end

  assign data_a_vld = vld_q[0];
  assign data_a_sop = sop_q[0];
  assign data_a_eop = eop_q[0];
  assign data_a     = data_q[0];
  assign data_b_vld = vld_q[1];
  assign data_b_sop = sop_q[1];
  assign data_b_eop = eop_q[1];
  assign data_b     = data_q[1];
  assign data_c_vld = vld_q[2];
  assign data_c_sop = sop_q[2];
  assign data_c_eop = eop_q[2];
  assign data_c     = data_q[2];
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_demux3.sv
// Directed bench for pkt_demux3: per-channel scoreboards fed from the stimulus,
// latency, backpressure, drop and reset checks.
module tb_pkt_demux3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [1:0]    din_chan = 2'd0;
  logic [2:0]    rdy_s = 3'b111;
  logic [2:0]    rdy_set = 3'b111;
  logic          rand_rdy = 1'b0;
  logic          data_a_vld, data_a_sop, data_a_eop, data_b_vld, data_b_sop, data_b_eop;
  logic          data_c_vld, data_c_sop, data_c_eop, drop_pulse;
  logic [DW-1:0] data_a, data_b, data_c;
  logic [15:0]   drop_cnt;

  int vec_cnt = 0, err_cnt = 0, cyc = 0, pulse_cnt = 0, hold_err = 0;
  int last_rise [3];
  int vld_cycles [3];
  int eop_cyc [3];
  int got_idx [3];
  int exp_idx [3];
  logic [9:0]  exp_q [3][$];
  logic [9:0]  got_q [3][$];
  logic [10:0] prev_t [3];
  logic [2:0]  prev_stall = 3'b000, vld_prev = 3'b000;
  logic [2:0]  vld, sop, eop;
  logic [DW-1:0] dat [3];

  assign vld = {data_c_vld, data_b_vld, data_a_vld};
  assign sop = {data_c_sop, data_b_sop, data_a_sop};
  assign eop = {data_c_eop, data_b_eop, data_a_eop};
  assign dat[0] = data_a;
  assign dat[1] = data_b;
  assign dat[2] = data_c;

  pkt_demux3 dut (
    .clk(clk), .rst_n(rst_n),
    .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop), .din(din), .din_chan(din_chan),
    .data_a_vld(data_a_vld), .data_a_sop(data_a_sop), .data_a_eop(data_a_eop),
    .data_a(data_a), .data_a_rdy(rdy_s[0]),
    .data_b_vld(data_b_vld), .data_b_sop(data_b_sop), .data_b_eop(data_b_eop),
    .data_b(data_b), .data_b_rdy(rdy_s[1]),
    .data_c_vld(data_c_vld), .data_c_sop(data_c_sop), .data_c_eop(data_c_eop),
    .data_c(data_c), .data_c_rdy(rdy_s[2]),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    rdy_s = rand_rdy ? 3'($urandom_range(0, 7)) : rdy_set;
  end

  // Monitor: capture transfers, vld rises, stall stability and drop pulses.
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rst_n && prev_stall[c] && ({vld[c], sop[c], eop[c], dat[c]} !== prev_t[c]))
        hold_err++;
      if (vld[c] === 1'b1 && vld_prev[c] !== 1'b1) last_rise[c] = cyc;
      if (vld[c] === 1'b1) vld_cycles[c]++;
      if (vld[c] === 1'b1 && rdy_s[c] === 1'b1) got_q[c].push_back({sop[c], eop[c], dat[c]});
      prev_stall[c] = rst_n && (vld[c] === 1'b1) && !rdy_s[c];
      prev_t[c]     = {vld[c], sop[c], eop[c], dat[c]};
      vld_prev[c]   = vld[c];
    end
    if (drop_pulse === 1'b1) pulse_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input logic [1:0] ch, input int base, input int len,
                          input bit with_eop, input bit keep);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      din_vld  = 1'b1;
      din_sop  = (i == 0);
      din_eop  = with_eop && (i == len - 1);
      din      = DW'(base + i);
      din_chan = (i == 0) ? ch : 2'd3;
      if (keep) exp_q[ch].push_back({din_sop, din_eop, din});
    end
    if (ch != 2'd3) eop_cyc[ch] = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
    end
  endtask

  task automatic check_chan(input int c, input string tag);
    check_val({tag, "_cnt"}, got_q[c].size() - got_idx[c], exp_q[c].size() - exp_idx[c]);
    while (got_idx[c] < got_q[c].size() && exp_idx[c] < exp_q[c].size()) begin
      check_val(tag, got_q[c][got_idx[c]], exp_q[c][exp_idx[c]]);
      got_idx[c]++;
      exp_idx[c]++;
    end
    got_idx[c] = got_q[c].size();
    exp_idx[c] = exp_q[c].size();
  endtask

  initial begin
    int vc0;
    for (int c = 0; c < 3; c++) begin
      last_rise[c] = 0; vld_cycles[c] = 0; eop_cyc[c] = 0; got_idx[c] = 0; exp_idx[c] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("rst_vld", {29'd0, vld}, 32'd0);
    check_val("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check_val("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    check_val("rst_data_a", {24'd0, data_a}, 32'd0);

    // Single packets on each channel with latency checks.
    send_pkt(2'd0, 0, 16, 1'b1, 1'b1);
    idle(30);
    check_val("lat_a", last_rise[0], eop_cyc[0] + 2);
    send_pkt(2'd1, 20, 21, 1'b1, 1'b1);
    idle(30);
    check_val("lat_b", last_rise[1], eop_cyc[1] + 2);
    send_pkt(2'd2, 50, 31, 1'b1, 1'b1);
    idle(40);
    check_val("lat_c", last_rise[2], eop_cyc[2] + 2);
    check_chan(0, "single_a");
    check_chan(1, "single_b");
    check_chan(2, "single_c");
    check_val("single_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // Backpressure: third 20-beat packet cannot be admitted.
    rdy_set = 3'b101;
    idle(2);
    send_pkt(2'd1, 100, 20, 1'b1, 1'b1);
    send_pkt(2'd1, 120, 20, 1'b1, 1'b1);
    send_pkt(2'd1, 140, 20, 1'b1, 1'b0);
    idle(5);
    check_val("bp_stall_vld", {31'd0, data_b_vld}, 32'd1);
    check_val("bp_stall_sop", {31'd0, data_b_sop}, 32'd1);
    check_val("bp_stall_data", {24'd0, data_b}, 32'd100);
    check_val("bp_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    rdy_set = 3'b111;
    idle(60);
    check_chan(1, "bp_b");

    // Illegal channel, then a sop arriving mid-packet.
    send_pkt(2'd3, 0, 5, 1'b1, 1'b0);
    idle(10);
    check_val("ill_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    send_pkt(2'd0, 200, 5, 1'b0, 1'b0);
    send_pkt(2'd0, 210, 8, 1'b1, 1'b1);
    idle(20);
    check_chan(0, "midsop_a");
    check_chan(1, "midsop_b");
    check_chan(2, "midsop_c");
    check_val("midsop_drop_cnt", {16'd0, drop_cnt}, 32'd3);

    // Oversize packet followed by a 1-beat packet.
    vc0 = vld_cycles[2];
    send_pkt(2'd2, 0, 33, 1'b1, 1'b0);
    idle(10);
    check_val("ovs_novld", vld_cycles[2] - vc0, 32'd0);
    check_val("ovs_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    send_pkt(2'd2, 99, 1, 1'b1, 1'b1);
    idle(10);
    check_val("one_beat_word", {22'd0, got_q[2][got_q[2].size() - 1]}, 32'h363);
    check_chan(2, "one_beat");

    // Pointer wrap with random consumer stalls.
    rand_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send_pkt(2'(k % 2), k * 30, 30, 1'b1, 1'b1);
      idle(60);
    end
    rand_rdy = 1'b0;
    idle(80);
    check_chan(0, "wrap_a");
    check_chan(1, "wrap_b");
    check_val("wrap_drop_cnt", {16'd0, drop_cnt}, 32'd4);
    check_val("drop_pulses", pulse_cnt, 32'd4);

    // Reset with buffered and partial data present.
    rdy_set = 3'b110;
    idle(2);
    send_pkt(2'd0, 1, 10, 1'b1, 1'b0);
    send_pkt(2'd0, 30, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("pre_rst_vld_a", {31'd0, data_a_vld}, 32'd1);
    din_vld = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("mid_rst_vld", {29'd0, vld}, 32'd0);
    check_val("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check_val("mid_rst_data_a", {24'd0, data_a}, 32'd0);
    rdy_set = 3'b111;
    idle(2);
    send_pkt(2'd0, 7, 5, 1'b1, 1'b1);
    idle(20);
    check_chan(0, "post_rst_a");
    check_chan(1, "post_rst_b");
    check_chan(2, "post_rst_c");
    check_val("post_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check_val("stall_hold", hold_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
